// File: rtl/serial_subtractor8_if.sv
// rtl/serial_subtractor8_if.sv - start/done handshake and operand/result bundle for serial_subtractor8
//
// Signals:
//   start          request from the controller, honoured only when the unit is free
//   A, B, Bin      minuend, subtrahend, borrow-in (captured on the accepting edge)
//   busy, done     in-progress level and one-cycle completion pulse
//   D, Bout        difference and final borrow-out, held until the next done
//   Z, N, V        zero / negative / signed-overflow flags (0 unless flags are built)
// Modports: master = ALU controller side, slave = subtractor side.

interface serial_subtractor8_if;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic       Bout;
    logic       Z;
    logic       N;
    logic       V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, Z, N, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, Z, N, V
    );
endinterface

// File: rtl/serial_subtractor8.sv
// rtl/serial_subtractor8.sv - bit-serial 8-bit subtractor D = A - B - Bin, LSB first
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any in-flight operation
//   bus    serial_subtractor8_if.slave: start/A/B/Bin in, busy/done/D/Bout/Z/N/V out
// Build option:
//   SERIAL_SUB_FLAGS_EN  when defined, Z/N/V registers are built and loaded with D;
//                        otherwise Z/N/V are tied to 0.
// Timing: accept at E0, bits 0..7 at E1..E8, done pulse after E8. A new start is
// taken on the edge that leaves DONE so back-to-back results come every 9 cycles.

module serial_subtractor8 (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_subtractor8_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;

    logic [7:0] a_sh_q, a_sh_d;
    logic [7:0] b_sh_q, b_sh_d;
    logic [7:0] res_sh_q, res_sh_d;
    logic       borrow_q, borrow_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] dout_q, dout_d;
    logic       bout_q, bout_d;

    logic       accept;
    logic       last_bit;
    logic       bit_diff;
    logic       borrow_nxt;
    logic [7:0] full_diff;

    // The unit is free in IDLE and also in DONE, whose exit edge may take a new request.
    assign accept     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit   = (state_q == S_SHIFT) && (cnt_q == 3'd7);

    // One full-subtractor cell applied to the LSBs of the operand shifters.
    assign bit_diff   = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    assign borrow_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    assign full_diff  = {bit_diff, res_sh_q[7:1]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 3'd7) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        bout_d   = bout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (accept) begin
            a_sh_d   = bus.A;
            b_sh_d   = bus.B;
            borrow_d = bus.Bin;
            cnt_d    = 3'd0;
            busy_d   = 1'b1;
        end else if (state_q == S_SHIFT) begin
            a_sh_d   = {1'b0, a_sh_q[7:1]};
            b_sh_d   = {1'b0, b_sh_q[7:1]};
            res_sh_d = full_diff;
            borrow_d = borrow_nxt;
            cnt_d    = cnt_q + 3'd1;
            busy_d   = !last_bit;
            if (last_bit) begin
                dout_d = full_diff;
                bout_d = borrow_nxt;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= 8'h00;
            b_sh_q   <= 8'h00;
            res_sh_q <= 8'h00;
            borrow_q <= 1'b0;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= 8'h00;
            bout_q   <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            bout_q   <= bout_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = dout_q;
    assign bus.Bout = bout_q;

`ifdef SERIAL_SUB_FLAGS_EN
    // Operand sign bits are kept aside because the shifters lose them during SHIFT.
    logic a7_q, a7_d;
    logic b7_q, b7_d;
    logic z_q, z_d;
    logic n_q, n_d;
    logic v_q, v_d;

    always_comb begin
        a7_d = a7_q;
        b7_d = b7_q;
        z_d  = z_q;
        n_d  = n_q;
        v_d  = v_q;
        if (accept) begin
            a7_d = bus.A[7];
            b7_d = bus.B[7];
        end else if (last_bit) begin
            z_d = (full_diff == 8'h00);
            n_d = full_diff[7];
            v_d = (a7_q ^ b7_q) & (a7_q ^ full_diff[7]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a7_q <= 1'b0;
            b7_q <= 1'b0;
            z_q  <= 1'b0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
        end else begin
            a7_q <= a7_d;
            b7_q <= b7_d;
            z_q  <= z_d;
            n_q  <= n_d;
            v_q  <= v_d;
        end
    end

    assign bus.Z = z_q;
    assign bus.N = n_q;
    assign bus.V = v_q;
`else
    assign bus.Z = 1'b0;
    assign bus.N = 1'b0;
    assign bus.V = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor8.sv
// tb/tb_serial_subtractor8.sv - self-checking bench for serial_subtractor8

module tb_serial_subtractor8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_subtractor8_if bus ();

    serial_subtractor8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] t;
        t = {1'b0, a} - {1'b0, b} - {8'h00, bin};
        return {({1'b0, a} < ({1'b0, b} + {8'h00, bin})), t[7:0]};
    endfunction

    // Issues one operation and checks latency, result and flags.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic ez, input logic en, input logic ev);
        logic [8:0] exp;
        int cyc;
        exp = ref_sub(a, b, bin);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = 8'hxx; bus.B = 8'hxx; bus.Bin = 1'bx;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== 8) begin bad++; $display("FAIL latency a=%h b=%h got=%0d exp=8", a, b, cyc); end
        total++;
        if (bus.D !== exp[7:0]) begin bad++; $display("FAIL D a=%h b=%h bin=%b got=%h exp=%h", a, b, bin, bus.D, exp[7:0]); end
        total++;
        if (bus.Bout !== exp[8]) begin bad++; $display("FAIL Bout a=%h b=%h got=%b exp=%b", a, b, bus.Bout, exp[8]); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b exp=0", bus.busy); end
`ifndef SERIAL_SUB_FLAGS_EN
        ez = 1'b0; en = 1'b0; ev = 1'b0;
`endif
        total++;
        if ({bus.Z, bus.N, bus.V} !== {ez, en, ev}) begin
            bad++; $display("FAIL flags a=%h b=%h got=%b%b%b exp=%b%b%b", a, b, bus.Z, bus.N, bus.V, ez, en, ev);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.A = 8'h00; bus.B = 8'h00; bus.Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.D, bus.Bout, bus.Z, bus.N, bus.V} !== 14'h0) begin
            bad++; $display("FAIL reset_state got busy=%b done=%b D=%h Bout=%b", bus.busy, bus.done, bus.D, bus.Bout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start;
        bus.start = 1'b1; bus.A = 8'h40; bus.B = 8'h13; bus.Bin = 1'b1;
        @(posedge clk); #1;                               // E0
        for (int e = 1; e <= 9; e++) begin
            if (e == 3 || e == 8) begin
                bus.start = 1'b1; bus.A = 8'h01; bus.B = 8'hF0; bus.Bin = 1'b0;
            end else if (e == 9) begin
                bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h20; bus.Bin = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (e < 8) begin
                total++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    bad++; $display("FAIL busy_window e=%0d busy=%b done=%b exp busy=1 done=0", e, bus.busy, bus.done);
                end
            end
            if (e == 8) begin
                total++;
                if (bus.done !== 1'b1 || bus.D !== 8'h2C || bus.Bout !== 1'b0) begin
                    bad++; $display("FAIL ignore_start done=%b D=%h Bout=%b exp done=1 D=2c Bout=0", bus.done, bus.D, bus.Bout);
                end
            end
        end
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL accept_e9 busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done);
        end
        repeat (8) @(posedge clk);                        // E10..E17
        #1;
        total++;
        if (bus.done !== 1'b1 || bus.D !== 8'hF0 || bus.Bout !== 1'b1) begin
            bad++; $display("FAIL e17_result done=%b D=%h Bout=%b exp done=1 D=f0 Bout=1", bus.done, bus.D, bus.Bout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen_done;
        bus.start = 1'b1; bus.A = 8'h99; bus.B = 8'h11; bus.Bin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);                        // E4
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.D, bus.Bout, bus.Z, bus.N, bus.V} !== 14'h0) begin
            bad++; $display("FAIL async_reset busy=%b done=%b D=%h Bout=%b exp all 0", bus.busy, bus.done, bus.D, bus.Bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin bad++; $display("FAIL discarded_op activity=%0d exp=0", seen_done); end
        run_op(8'hC8, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        logic       bin;
        logic [8:0] exp;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            exp = ref_sub(a, b, bin);
            bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
            @(posedge clk); #1;
            bus.start = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            total++;
            if (bus.done !== 1'b1 || bus.D !== exp[7:0] || bus.Bout !== exp[8]) begin
                bad++;
                $display("FAIL b2b i=%0d a=%h b=%h bin=%b got done=%b D=%h Bout=%b exp D=%h Bout=%b",
                         i, a, b, bin, bus.done, bus.D, bus.Bout, exp[7:0], exp[8]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
